// File: rtl/fetch_stage.sv
// Front-end fetcher: one imem read at a time, packet {pc, insn, mask} held for decode.
// Latency: rsp_valid at cycle M -> fetch_bus_is_busy at M+1; next request the cycle after recv.
// Backpressure: request held stable until imem_req_ready; packet held stable until fetch_bus_recv.
module fetch_stage #(
    parameter int         CORE_ID     = 0,
    parameter int         PC_WIDTH    = 64,
    parameter int         INSN_WIDTH  = 32,
    parameter int         MASK_WIDTH  = 8,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    input  logic [MASK_WIDTH-1:0] start_mask,
    output logic                  imem_req_valid,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [INSN_WIDTH-1:0] imem_rsp_data,
    output logic                  fetch_bus_is_busy,
    output logic [PC_WIDTH-1:0]   fetch_bus_pc,
    output logic [INSN_WIDTH-1:0] fetch_bus_insn,
    output logic [MASK_WIDTH-1:0] fetch_bus_exec_mask,
    input  logic                  fetch_bus_recv,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic [MASK_WIDTH-1:0] redirect_mask,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DISCARD,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t                  state_q,     state_d;
    logic [PC_WIDTH-1:0]     pc_q,        pc_d;
    logic [MASK_WIDTH-1:0]   mask_q,      mask_d;
    logic                    busy_q,      busy_d;
    logic [PC_WIDTH-1:0]     bus_pc_q,    bus_pc_d;
    logic [INSN_WIDTH-1:0]   bus_insn_q,  bus_insn_d;
    logic [MASK_WIDTH-1:0]   bus_mask_q,  bus_mask_d;
    logic                    halted_q,    halted_d;

    // CORE_ID is identification only; no logic depends on it.
    logic [31:0] unused_core_id;
    assign unused_core_id = 32'(CORE_ID);

    // Next-state: the in-flight request is never re-issued; a redirect either
    // retargets an unaccepted request or turns the outstanding one into a discard.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        bus_pc_d   = bus_pc_q;
        bus_insn_d = bus_insn_q;
        bus_mask_d = bus_mask_q;
        halted_d   = halted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    mask_d  = start_mask;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    mask_d  = redirect_mask;
                    // An accepted old-address request must still drain.
                    state_d = imem_req_ready ? S_DISCARD : S_REQ;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    mask_d  = redirect_mask;
                    state_d = imem_rsp_valid ? S_REQ : S_DISCARD;
                end else if (imem_rsp_valid) begin
                    bus_pc_d   = pc_q;
                    bus_insn_d = imem_rsp_data;
                    bus_mask_d = mask_q;
                    busy_d     = 1'b1;
                    pc_d       = pc_q + PC_WIDTH'(4);
                    state_d    = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    mask_d = redirect_mask;
                end
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                // Redirect beats a same-cycle recv: the packet is squashed.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    mask_d  = redirect_mask;
                    busy_d  = 1'b0;
                    state_d = S_REQ;
                end else if (fetch_bus_recv && busy_q) begin
                    busy_d = 1'b0;
                    if (bus_insn_q[7:0] == HALT_OPCODE) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HALTED: begin
                if (redirect_valid) begin
                    pc_d     = redirect_pc;
                    mask_d   = redirect_mask;
                    halted_d = 1'b0;
                    state_d  = S_REQ;
                end else if (start) begin
                    pc_d     = start_pc;
                    mask_d   = start_mask;
                    halted_d = 1'b0;
                    state_d  = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and packet registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            bus_pc_q   <= '0;
            bus_insn_q <= '0;
            bus_mask_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            bus_pc_q   <= bus_pc_d;
            bus_insn_q <= bus_insn_d;
            bus_mask_q <= bus_mask_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req_valid      = (state_q == S_REQ);
    assign imem_req_addr       = pc_q;
    assign fetch_bus_is_busy   = busy_q;
    assign fetch_bus_pc        = bus_pc_q;
    assign fetch_bus_insn      = bus_insn_q;
    assign fetch_bus_exec_mask = bus_mask_q;
    assign halted              = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a transaction-level reference model.
// Latency: one step per clock; inputs driven and outputs sampled on the falling edge.
// Backpressure: random imem_req_ready, response latency and decode recv.
module tb_fetch_stage;

    localparam int CORE_ID = 0;
    localparam int PCW     = 64;
    localparam int IW      = 32;
    localparam int MW      = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [PCW-1:0] start_pc;
    logic [MW-1:0]  start_mask;
    logic           imem_req_valid;
    logic [PCW-1:0] imem_req_addr;
    logic           imem_req_ready;
    logic           imem_rsp_valid;
    logic [IW-1:0]  imem_rsp_data;
    logic           fetch_bus_is_busy;
    logic [PCW-1:0] fetch_bus_pc;
    logic [IW-1:0]  fetch_bus_insn;
    logic [MW-1:0]  fetch_bus_exec_mask;
    logic           fetch_bus_recv;
    logic           redirect_valid;
    logic [PCW-1:0] redirect_pc;
    logic [MW-1:0]  redirect_mask;
    logic           halted;

    fetch_stage #(
        .CORE_ID(CORE_ID), .PC_WIDTH(PCW), .INSN_WIDTH(IW),
        .MASK_WIDTH(MW), .HALT_OPCODE(8'hFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .start_mask(start_mask), .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .fetch_bus_is_busy(fetch_bus_is_busy), .fetch_bus_pc(fetch_bus_pc),
        .fetch_bus_insn(fetch_bus_insn), .fetch_bus_exec_mask(fetch_bus_exec_mask),
        .fetch_bus_recv(fetch_bus_recv), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_mask(redirect_mask), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus knobs and one-shot injections
    int p_ready = 100, p_recv = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit inj_rst = 0, inj_start = 0, inj_redir = 0, inj_recv = 0;
    logic [PCW-1:0] inj_spc = '0, inj_rpc = '0;
    logic [MW-1:0]  inj_smask = '0, inj_rmask = '0;

    // Memory model: single pending response
    bit             pend = 0;
    int             lat = 0;
    logic [IW-1:0]  pend_data = '0;
    int             outstanding = 0;
    logic [PCW-1:0] acc_q[$];

    // Reference model: fetch stream as "next pc to be delivered"
    bit             chk_en = 0, m_running = 0, m_halted = 0, m_redir_last = 0, prev_busy = 0;
    logic [PCW-1:0] exp_pc = '0, pkt_pc = '0;
    logic [MW-1:0]  exp_mask = '0, pkt_mask = '0;
    logic [IW-1:0]  pkt_insn = '0;
    int             n_pkts = 0, busy_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory contents; HALT only at 0x200 and at addresses ending in 0xA54.
    function automatic logic [IW-1:0] mem_word(input logic [PCW-1:0] a);
        logic [7:0] op;
        op = a[9:2] ^ 8'h5A;
        if (op == 8'hFF) op = 8'h01;
        if (a == 64'h200 || a[11:0] == 12'hA54) op = 8'hFF;
        return {a[31:8] ^ 24'hC0FFEE, op};
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_req_addr"}, imem_req_addr, 0);
        check({tag, "_busy"}, fetch_bus_is_busy, 0);
        check({tag, "_pc"}, fetch_bus_pc, 0);
        check({tag, "_insn"}, fetch_bus_insn, 0);
        check({tag, "_mask"}, fetch_bus_exec_mask, 0);
        check({tag, "_halted"}, halted, 0);
    endtask

    task automatic step();
        logic [PCW-1:0] rpc;
        @(negedge clk);
        // Observe the result of the previous edge
        if (chk_en) begin
            if (m_redir_last) check("drop_on_redirect", fetch_bus_is_busy, 0);
            if (!m_running || m_halted) begin
                check("stopped_no_req", imem_req_valid, 0);
                check("stopped_not_busy", fetch_bus_is_busy, 0);
            end
            check("halted_flag", halted, m_halted);
            if (fetch_bus_is_busy) begin
                check("no_req_in_hold", imem_req_valid, 0);
                if (!prev_busy) begin
                    pkt_pc   = exp_pc;
                    pkt_insn = mem_word(exp_pc);
                    pkt_mask = exp_mask;
                    exp_pc   = exp_pc + 64'd4;
                    n_pkts++;
                    $display("FETCH core=%0d pc=%h insn=%h", CORE_ID, fetch_bus_pc, fetch_bus_insn);
                end
                busy_cycles++;
                check("pkt_pc", fetch_bus_pc, pkt_pc);
                check("pkt_insn", fetch_bus_insn, pkt_insn);
                check("pkt_mask", fetch_bus_exec_mask, pkt_mask);
            end
        end
        prev_busy = fetch_bus_is_busy;

        // Drive inputs for the next edge
        rst_n          = !inj_rst;
        imem_req_ready = ($urandom_range(99) < p_ready);
        fetch_bus_recv = inj_recv || ($urandom_range(99) < p_recv);
        start          = inj_start;
        start_pc       = inj_spc;
        start_mask     = inj_smask;
        if (inj_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = inj_rpc;
            redirect_mask  = inj_rmask;
        end else if ($urandom_range(99) < p_redir) begin
            rpc = 64'h1000 + (64'($urandom_range(1023)) << 2);
            if ($urandom_range(7) == 0) rpc[1:0] = 2'($urandom_range(3));
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
            redirect_mask  = 8'($urandom_range(255));
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = 64'($urandom);
            redirect_mask  = 8'($urandom_range(255));
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) begin
            if (lat <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_data;
                pend           = 0;
                outstanding    = 0;
            end else begin
                lat--;
            end
        end
        if (imem_req_valid && imem_req_ready && rst_n) begin
            check("single_outstanding", outstanding, 0);
            outstanding = 1;
            pend        = 1;
            pend_data   = mem_word(imem_req_addr);
            lat         = $urandom_range(lat_max, lat_min);
            acc_q.push_back(imem_req_addr);
        end

        // Model reaction to these inputs at the coming edge
        m_redir_last = 0;
        if (!rst_n) begin
            chk_en = 1; m_running = 0; m_halted = 0; outstanding = 0;
        end else if (!m_running) begin
            if (start) begin m_running = 1; exp_pc = start_pc; exp_mask = start_mask; end
        end else if (m_halted) begin
            if (redirect_valid) begin m_halted = 0; exp_pc = redirect_pc; exp_mask = redirect_mask; end
            else if (start) begin m_halted = 0; exp_pc = start_pc; exp_mask = start_mask; end
        end else if (redirect_valid) begin
            exp_pc = redirect_pc; exp_mask = redirect_mask; m_redir_last = 1;
        end else if (fetch_bus_recv && fetch_bus_is_busy && pkt_insn[7:0] == 8'hFF) begin
            m_halted = 1;
        end
        inj_rst = 0; inj_start = 0; inj_redir = 0; inj_recv = 0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!fetch_bus_is_busy && n < 60) begin step(); n++; end
        check(tag, fetch_bus_is_busy, 1);
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        while (outstanding == 0 && n < 60) begin step(); n++; end
        check(tag, outstanding, 1);
    endtask

    initial begin
        int snap;
        rst_n = 0; start = 0; start_pc = '0; start_mask = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        fetch_bus_recv = 0; redirect_valid = 0; redirect_pc = '0; redirect_mask = '0;

        // Reset, then plain sequential fetch with 1-cycle memory
        inj_rst = 1; step();
        inj_rst = 1; step();
        check_zero_outputs("reset");
        acc_q.delete(); n_pkts = 0; busy_cycles = 0;
        inj_start = 1; inj_spc = 64'h100; inj_smask = 8'hFF;
        repeat (14) step();
        check("t1_req_count", acc_q.size() >= 3, 1);
        check("t1_req0", acc_q[0], 64'h100);
        check("t1_req1", acc_q[1], 64'h104);
        check("t1_req2", acc_q[2], 64'h108);
        check("t1_busy_one_cycle", busy_cycles, n_pkts);

        // Decode stall: packet held, no requests, next request right after recv
        p_recv = 0; lat_min = 3; lat_max = 3;
        wait_busy("t2_busy_timeout");
        repeat (5) step();
        check("t2_still_busy", fetch_bus_is_busy, 1);
        inj_recv = 1; step();
        step();
        check("t2_req_after_recv", imem_req_valid, 1);
        check("t2_req_addr", imem_req_addr, exp_pc);

        // Redirect while waiting for a response
        p_recv = 100;
        wait_accept("t3_accept_timeout");
        step();
        inj_redir = 1; inj_rpc = 64'h400; inj_rmask = 8'h0F; step();
        wait_busy("t3_busy_timeout");
        check("t3_pkt_pc", fetch_bus_pc, 64'h400);
        check("t3_pkt_mask", fetch_bus_exec_mask, 8'h0F);

        // Redirect and recv together in HOLD, then a stalled request
        p_recv = 0;
        step(); step();
        wait_busy("t4_busy_timeout");
        p_ready = 0;
        inj_redir = 1; inj_rpc = 64'h800; inj_rmask = 8'h33; inj_recv = 1; step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_req_valid", imem_req_valid, 1);
            check("t4_req_addr", imem_req_addr, 64'h800);
            check("t4_not_busy", fetch_bus_is_busy, 0);
        end
        p_ready = 100; p_recv = 100;

        // HALT at 0x200, then restart by redirect
        inj_redir = 1; inj_rpc = 64'h200; inj_rmask = 8'hFF; step();
        begin
            int n = 0;
            while (!halted && n < 60) begin step(); n++; end
        end
        check("t5_halted", halted, 1);
        snap = acc_q.size();
        repeat (20) step();
        check("t5_no_req_when_halted", acc_q.size(), snap);
        inj_redir = 1; inj_rpc = 64'h300; inj_rmask = 8'hFF; step();
        step();
        check("t5_unhalted", halted, 0);
        check("t5_restart_req", imem_req_valid, 1);
        check("t5_restart_addr", imem_req_addr, 64'h300);

        // PC wrap, then reset while a response is outstanding
        inj_rst = 1; step();
        inj_rst = 1; step();
        check_zero_outputs("t6_reset");
        lat_min = 1; lat_max = 1;
        repeat (4) step();
        acc_q.delete();
        inj_start = 1; inj_spc = 64'hFFFF_FFFF_FFFF_FFFC; inj_smask = 8'hA5;
        begin
            int n = 0;
            while (acc_q.size() < 2 && n < 60) begin step(); n++; end
        end
        check("t6_req0", acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t6_req1_wrap", acc_q[1], 64'h0);
        lat_min = 3; lat_max = 3;
        wait_accept("t6_accept_timeout");
        step();
        inj_rst = 1; step();
        step();
        check_zero_outputs("t6_midreset");
        snap = n_pkts;
        repeat (6) step();
        check("t6_late_rsp_ignored", fetch_bus_is_busy, 0);
        check("t6_no_pkt_after_reset", n_pkts, snap);

        // Random traffic against the model
        p_ready = 70; p_recv = 60; p_redir = 4; lat_min = 1; lat_max = 4;
        snap = n_pkts;
        inj_start = 1; inj_spc = 64'h1000; inj_smask = 8'hFF;
        repeat (4000) step();
        check("rand_progress", (n_pkts - snap) > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
